// File: rtl/icache_pkg.sv
// Shared constants and FSM state type for the instruction cache.
// Memory-controller encodings match the controller's icache port.
package icache_pkg;

  localparam logic [1:0] TASK_SRC_ICACHE = 2'b10;
  localparam logic [1:0] TASK_SRC_LSB    = 2'b01;
  localparam logic [2:0] LS_TYPE_LW      = 3'b000;
  localparam logic       LS_READ         = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for a direct-mapped, one-word-per-line cache.
// One combinational read port, one write port; a same-index write is forwarded to the read port.
module icache_line_store #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = 24,
  parameter int DATA_W     = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [INDEX_BITS-1:0] rd_idx_in,
  output logic                  rd_valid_out,
  output logic [TAG_W-1:0]      rd_tag_out,
  output logic [DATA_W-1:0]     rd_data_out,
  input  logic                  wr_en_in,
  input  logic [INDEX_BITS-1:0] wr_idx_in,
  input  logic [TAG_W-1:0]      wr_tag_in,
  input  logic [DATA_W-1:0]     wr_data_in
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];
  logic              w_bypass;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid <= '0;
    end else if (wr_en_in) begin
      r_valid[wr_idx_in] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      r_tag[wr_idx_in]  <= wr_tag_in;
      r_data[wr_idx_in] <= wr_data_in;
    end
  end

  assign w_bypass     = wr_en_in && (wr_idx_in == rd_idx_in);
  assign rd_valid_out = w_bypass | r_valid[rd_idx_in];
  assign rd_tag_out   = w_bypass ? wr_tag_in  : r_tag[rd_idx_in];
  assign rd_data_out  = w_bypass ? wr_data_in : r_data[rd_idx_in];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle registered hits, single-word LW refill
// through the memory controller's icache port, with flush cancelling the pending response.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int ADDR_W     = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              fetch_req_in,
  input  logic [ADDR_W-1:0] fetch_addr_in,
  input  logic              flush_in,
  output logic [31:0]       inst_out,
  output logic              inst_valid_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [31:0]       mem_data_out,
  output logic              mem_r_nw_out,
  output logic [2:0]        mem_type_out,
  output logic              mem_activate_out,
  input  logic [31:0]       mem_data_in,
  input  logic              mem_data_avail_in,
  input  logic [1:0]        mem_task_src_in,
  input  logic              mem_block_in
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  icache_state_e r_state, w_state_nxt;

  logic                  r_cancel, w_cancel_nxt;
  logic                  r_inst_valid, w_inst_valid_nxt;
  logic                  r_mem_act, w_mem_act_nxt;
  logic [31:0]           r_inst, w_inst_nxt;
  logic [ADDR_W-1:0]     r_mem_addr, w_mem_addr_nxt;

  logic [INDEX_BITS-1:0] w_rd_idx;
  logic [TAG_W-1:0]      w_req_tag;
  logic                  w_rd_valid;
  logic [TAG_W-1:0]      w_rd_tag;
  logic [31:0]           w_rd_data;
  logic                  w_hit;
  logic                  w_fill;
  logic                  w_wr_en;
  logic                  w_unused;

  assign w_rd_idx  = fetch_addr_in[INDEX_BITS+1:2];
  assign w_req_tag = fetch_addr_in[ADDR_W-1:INDEX_BITS+2];
  assign w_hit     = w_rd_valid && (w_rd_tag == w_req_tag);

  // Controller data is combinational and only valid in this cycle; LSB returns are ignored.
  assign w_fill    = (r_state == ST_MISS) && mem_data_avail_in &&
                     (mem_task_src_in == TASK_SRC_ICACHE);
  assign w_wr_en   = w_fill && rdy_in;

  icache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .DATA_W     (32)
  ) u_line_store (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rd_idx_in    (w_rd_idx),
    .rd_valid_out (w_rd_valid),
    .rd_tag_out   (w_rd_tag),
    .rd_data_out  (w_rd_data),
    .wr_en_in     (w_wr_en),
    .wr_idx_in    (r_mem_addr[INDEX_BITS+1:2]),
    .wr_tag_in    (r_mem_addr[ADDR_W-1:INDEX_BITS+2]),
    .wr_data_in   (mem_data_in)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_cancel_nxt     = r_cancel;
    w_inst_valid_nxt = 1'b0;
    w_mem_act_nxt    = r_mem_act;
    w_inst_nxt       = r_inst;
    w_mem_addr_nxt   = r_mem_addr;
    case (r_state)
      ST_IDLE: begin
        if (fetch_req_in && !flush_in) begin
          if (w_hit) begin
            w_inst_nxt       = w_rd_data;
            w_inst_valid_nxt = 1'b1;
          end else begin
            w_mem_addr_nxt = {fetch_addr_in[ADDR_W-1:2], 2'b00};
            w_mem_act_nxt  = 1'b1;
            w_state_nxt    = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        if (flush_in) begin
          w_cancel_nxt = 1'b1;
        end
        // The bus read cannot be aborted, so a cancelled fill still lands in the array.
        if (w_fill) begin
          w_inst_nxt       = mem_data_in;
          w_inst_valid_nxt = !(r_cancel || flush_in);
          w_mem_act_nxt    = 1'b0;
          w_cancel_nxt     = 1'b0;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cancel     <= 1'b0;
      r_inst_valid <= 1'b0;
      r_mem_act    <= 1'b0;
      r_inst       <= '0;
      r_mem_addr   <= '0;
    end else if (rdy_in) begin
      r_cancel     <= w_cancel_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_mem_act    <= w_mem_act_nxt;
      r_inst       <= w_inst_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
    end
  end

  assign inst_out         = r_inst;
  assign inst_valid_out   = r_inst_valid;
  assign mem_addr_out     = r_mem_addr;
  assign mem_activate_out = r_mem_act;
  assign mem_data_out     = '0;
  assign mem_r_nw_out     = LS_READ;
  assign mem_type_out     = LS_TYPE_LW;

  // Controller block status needs no action; word-offset bits never address anything.
  assign w_unused = ^{mem_block_in, fetch_addr_in[1:0], r_mem_addr[1:0]};

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, hits, conflicts, LSB contention,
// flushes, reset mid-miss and rdy_in freeze, with a cycle-scripted controller model.
module tb_icache;
  import icache_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        fetch_req_in;
  logic [31:0] fetch_addr_in;
  logic        flush_in;
  logic [31:0] inst_out;
  logic        inst_valid_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic        mem_r_nw_out;
  logic [2:0]  mem_type_out;
  logic        mem_activate_out;
  logic [31:0] mem_data_in;
  logic        mem_data_avail_in;
  logic [1:0]  mem_task_src_in;
  logic        mem_block_in;

  int tests = 0;
  int fails = 0;

  icache #(.INDEX_BITS(6), .ADDR_W(32)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .fetch_req_in      (fetch_req_in),
    .fetch_addr_in     (fetch_addr_in),
    .flush_in          (flush_in),
    .inst_out          (inst_out),
    .inst_valid_out    (inst_valid_out),
    .mem_addr_out      (mem_addr_out),
    .mem_data_out      (mem_data_out),
    .mem_r_nw_out      (mem_r_nw_out),
    .mem_type_out      (mem_type_out),
    .mem_activate_out  (mem_activate_out),
    .mem_data_in       (mem_data_in),
    .mem_data_avail_in (mem_data_avail_in),
    .mem_task_src_in   (mem_task_src_in),
    .mem_block_in      (mem_block_in)
  );

  always #5 clk_in = ~clk_in;

  // Request issued at cycle t; controller accepts at t+1 after lsb_cyc cycles of LSB traffic,
  // returns the word at t+5 (+lsb_cyc). Returns at cycle t+6 with fetch_req_in still driven.
  // flush_at (0..4) raises flush_in that many cycles after acceptance; -1 means no flush.
  task automatic run_miss(input logic [31:0] pc, input logic [31:0] word,
                          input int lsb_cyc, input int flush_at, output logic hold_ok);
    hold_ok = 1'b1;
    @(negedge clk_in);
    fetch_req_in  = 1'b1;
    fetch_addr_in = pc;
    for (int i = 0; i < lsb_cyc + 5; i++) begin
      @(negedge clk_in);
      mem_data_avail_in = 1'b0;
      mem_task_src_in   = 2'b00;
      flush_in          = 1'b0;
      if (mem_activate_out !== 1'b1 || mem_addr_out !== {pc[31:2], 2'b00} ||
          inst_valid_out !== 1'b0)
        hold_ok = 1'b0;
      if (i < lsb_cyc) begin
        if (i == lsb_cyc - 1) begin
          mem_data_avail_in = 1'b1;
          mem_task_src_in   = TASK_SRC_LSB;
          mem_data_in       = 32'hDEAD_BEEF;
        end
      end else if (i == lsb_cyc + 4) begin
        mem_data_avail_in = 1'b1;
        mem_task_src_in   = TASK_SRC_ICACHE;
        mem_data_in       = word;
      end
      if (flush_at >= 0 && i == lsb_cyc + flush_at) begin
        flush_in     = 1'b1;
        fetch_req_in = 1'b0;
      end
    end
    @(negedge clk_in);
    mem_data_avail_in = 1'b0;
    mem_task_src_in   = 2'b00;
    mem_data_in       = 32'h0;
    flush_in          = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; fetch_req_in = 1'b0; fetch_addr_in = 32'h0;
    flush_in = 1'b0; mem_data_in = 32'h0; mem_data_avail_in = 1'b0;
    mem_task_src_in = 2'b00; mem_block_in = 1'b0;
    #12;
    tests++; if (inst_valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", inst_valid_out); end
    tests++; if (mem_activate_out !== 1'b0) begin fails++; $display("FAIL reset_act: got %b want 0", mem_activate_out); end
    tests++; if (inst_out !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h want 0", inst_out); end
    tests++; if (mem_addr_out !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr_out); end
    tests++; if (mem_data_out !== 32'h0) begin fails++; $display("FAIL const_data: got %h want 0", mem_data_out); end
    tests++; if (mem_r_nw_out !== 1'b1) begin fails++; $display("FAIL const_rnw: got %b want 1", mem_r_nw_out); end
    tests++; if (mem_type_out !== 3'b000) begin fails++; $display("FAIL const_type: got %b want 000", mem_type_out); end
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_cold_miss();
    logic ok;
    run_miss(32'h0000_0100, 32'h0051_0113, 0, -1, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL cold_hold: got %b want 1", ok); end
    tests++; if (inst_valid_out !== 1'b1) begin fails++; $display("FAIL cold_valid: got %b want 1", inst_valid_out); end
    tests++; if (inst_out !== 32'h0051_0113) begin fails++; $display("FAIL cold_inst: got %h want 00510113", inst_out); end
    tests++; if (mem_activate_out !== 1'b0) begin fails++; $display("FAIL cold_act_drop: got %b want 0", mem_activate_out); end
    fetch_req_in = 1'b0;
    @(negedge clk_in);
    tests++; if (inst_valid_out !== 1'b0) begin fails++; $display("FAIL cold_pulse: got %b want 0", inst_valid_out); end
  endtask

  task automatic test_hit();
    logic ok;
    logic [31:0] pcs [4];
    logic [31:0] words [4];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108; pcs[3] = 32'h10D;
    words[0] = 32'h0051_0113; words[1] = 32'h0041_0093;
    words[2] = 32'h0000_0013; words[3] = 32'hFFF0_0F13;
    for (int i = 1; i < 4; i++) begin
      run_miss(pcs[i], words[i], 0, -1, ok);
      tests++; if (inst_out !== words[i] || ok !== 1'b1) begin fails++; $display("FAIL hit_prefill%0d: got %h want %h", i, inst_out, words[i]); end
      fetch_req_in = 1'b0;
      @(negedge clk_in);
    end
    @(negedge clk_in);
    fetch_req_in  = 1'b1;
    fetch_addr_in = pcs[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      tests++; if (inst_valid_out !== 1'b1 || inst_out !== words[i]) begin fails++; $display("FAIL hit_burst%0d: got v=%b %h want v=1 %h", i, inst_valid_out, inst_out, words[i]); end
      tests++; if (mem_activate_out !== 1'b0) begin fails++; $display("FAIL hit_noact%0d: got %b want 0", i, mem_activate_out); end
      if (i < 3) fetch_addr_in = pcs[i+1];
      else fetch_req_in = 1'b0;
    end
    @(negedge clk_in);
    tests++; if (inst_valid_out !== 1'b0) begin fails++; $display("FAIL hit_end: got %b want 0", inst_valid_out); end
  endtask

  task automatic test_conflict();
    logic ok;
    run_miss(32'h0000_0200, 32'hAAAA_0001, 0, -1, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL conf_miss200: got %b want 1", ok); end
    tests++; if (inst_valid_out !== 1'b1 || inst_out !== 32'hAAAA_0001) begin fails++; $display("FAIL conf_inst200: got %h want aaaa0001", inst_out); end
    fetch_req_in = 1'b0;
    run_miss(32'h0000_0100, 32'h1111_2222, 0, -1, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL conf_miss100: got %b want 1", ok); end
    tests++; if (inst_valid_out !== 1'b1 || inst_out !== 32'h1111_2222) begin fails++; $display("FAIL conf_inst100: got %h want 11112222", inst_out); end
    fetch_req_in = 1'b0;
  endtask

  task automatic test_lsb_priority();
    logic ok;
    run_miss(32'h0000_0302, 32'h1234_5678, 10, -1, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL lsb_hold: got %b want 1", ok); end
    tests++; if (inst_valid_out !== 1'b1 || inst_out !== 32'h1234_5678) begin fails++; $display("FAIL lsb_inst: got v=%b %h want v=1 12345678", inst_valid_out, inst_out); end
    fetch_req_in = 1'b0;
    @(negedge clk_in);
    fetch_req_in  = 1'b1;
    fetch_addr_in = 32'h0000_0300;
    @(negedge clk_in);
    tests++; if (inst_valid_out !== 1'b1 || inst_out !== 32'h1234_5678 || mem_activate_out !== 1'b0) begin fails++; $display("FAIL lsb_rehit: got v=%b %h act=%b want v=1 12345678 act=0", inst_valid_out, inst_out, mem_activate_out); end
    fetch_req_in = 1'b0;
  endtask

  task automatic test_flush();
    logic ok;
    run_miss(32'h0000_0400, 32'h0400_0001, 0, 2, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL flush_hold: got %b want 1", ok); end
    tests++; if (inst_valid_out !== 1'b0 || mem_activate_out !== 1'b0) begin fails++; $display("FAIL flush_nores: got v=%b act=%b want 0 0", inst_valid_out, mem_activate_out); end
    @(negedge clk_in);
    tests++; if (inst_valid_out !== 1'b0) begin fails++; $display("FAIL flush_late: got %b want 0", inst_valid_out); end
    fetch_req_in  = 1'b1;
    fetch_addr_in = 32'h0000_0400;
    @(negedge clk_in);
    tests++; if (inst_valid_out !== 1'b1 || inst_out !== 32'h0400_0001 || mem_activate_out !== 1'b0) begin fails++; $display("FAIL flush_rehit: got v=%b %h act=%b want v=1 04000001 act=0", inst_valid_out, inst_out, mem_activate_out); end
    fetch_req_in = 1'b0;
    // flush coinciding with the fill edge
    run_miss(32'h0000_0500, 32'h0500_0002, 0, 4, ok);
    tests++; if (inst_valid_out !== 1'b0 || mem_activate_out !== 1'b0) begin fails++; $display("FAIL flush_fill: got v=%b act=%b want 0 0", inst_valid_out, mem_activate_out); end
    fetch_req_in  = 1'b1;
    fetch_addr_in = 32'h0000_0500;
    @(negedge clk_in);
    tests++; if (inst_valid_out !== 1'b1 || inst_out !== 32'h0500_0002) begin fails++; $display("FAIL flush_fill_rehit: got v=%b %h want v=1 05000002", inst_valid_out, inst_out); end
    // flush in IDLE drops the same-cycle request
    fetch_addr_in = 32'h0000_0104;
    flush_in      = 1'b1;
    @(negedge clk_in);
    tests++; if (inst_valid_out !== 1'b0 || mem_activate_out !== 1'b0) begin fails++; $display("FAIL flush_idle: got v=%b act=%b want 0 0", inst_valid_out, mem_activate_out); end
    flush_in = 1'b0;
    @(negedge clk_in);
    tests++; if (inst_valid_out !== 1'b1 || inst_out !== 32'h0041_0093) begin fails++; $display("FAIL flush_idle_after: got v=%b %h want v=1 00410093", inst_valid_out, inst_out); end
    fetch_req_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_rdy_freeze();
    @(negedge clk_in);
    fetch_req_in  = 1'b1;
    fetch_addr_in = 32'h0000_0108;
    @(negedge clk_in);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      tests++; if (inst_valid_out !== 1'b1 || inst_out !== 32'h0000_0013 || mem_activate_out !== 1'b0) begin fails++; $display("FAIL rdy_freeze%0d: got v=%b %h act=%b want v=1 00000013 act=0", i, inst_valid_out, inst_out, mem_activate_out); end
    end
    rdy_in       = 1'b1;
    fetch_req_in = 1'b0;
    @(negedge clk_in);
    tests++; if (inst_valid_out !== 1'b0) begin fails++; $display("FAIL rdy_resume: got %b want 0", inst_valid_out); end
  endtask

  task automatic test_reset_mid_miss();
    logic ok;
    @(negedge clk_in);
    fetch_req_in  = 1'b1;
    fetch_addr_in = 32'h0000_0600;
    @(negedge clk_in);
    tests++; if (mem_activate_out !== 1'b1 || mem_addr_out !== 32'h0000_0600) begin fails++; $display("FAIL rmm_act: got act=%b %h want act=1 00000600", mem_activate_out, mem_addr_out); end
    #2 rst_in = 1'b0;
    #1;
    tests++; if (mem_activate_out !== 1'b0 || mem_addr_out !== 32'h0 || inst_valid_out !== 1'b0 || inst_out !== 32'h0) begin fails++; $display("FAIL rmm_outs: got act=%b addr=%h v=%b inst=%h want all 0", mem_activate_out, mem_addr_out, inst_valid_out, inst_out); end
    fetch_req_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    // previously filled line must miss after reset
    run_miss(32'h0000_0104, 32'h0041_0093, 0, -1, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rmm_invalid: got %b want 1", ok); end
    tests++; if (inst_valid_out !== 1'b1 || inst_out !== 32'h0041_0093) begin fails++; $display("FAIL rmm_refill: got v=%b %h want v=1 00410093", inst_valid_out, inst_out); end
    fetch_req_in = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_lsb_priority();
    test_flush();
    test_rdy_freeze();
    test_reset_mid_miss();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
